carregador_hd: RTL and testbench

CARREGADOR_HD -- requirements
Module: carregador_hd

---
 rtl/carregador_hd_if.sv | 33 +++
 rtl/carregador_hd.sv | 137 +++++++++++++
 tb/tb_carregador_hd.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/carregador_hd_if.sv
// Bus bundle between the HD program loader and its environment: control/table
// inputs, the HD read port, the instruction-memory write port and status flags.
interface carregador_hd_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 3
);
    logic              start;
    logic [31:0]       bloco;
    logic              abort;
    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_idx;
    logic [ADDR_W-1:0] tbl_len;
    logic              hd_rd;
    logic [ADDR_W-1:0] hd_addr;
    logic [DATA_W-1:0] hd_data;
    logic              inst_we;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, bloco, abort, tbl_we, tbl_idx, tbl_len, hd_data,
        input  hd_rd, hd_addr, inst_we, inst_addr, inst_data, busy, done, err
    );

    modport slave (
        input  start, bloco, abort, tbl_we, tbl_idx, tbl_len, hd_data,
        output hd_rd, hd_addr, inst_we, inst_addr, inst_data, busy, done, err
    );
endinterface

// File: rtl/carregador_hd.sv
// Copies one program block from the HD into instruction memory, word by word,
// using a per-block length table; bad requests finish immediately with err.
module carregador_hd #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BLOCK_SIZE = 200,
    parameter int NUM_BLOCKS = 8,
    parameter int HD_LAT     = 1,
    localparam int IDX_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    carregador_hd_if.slave  bus
);
    localparam int LAT_W = (HD_LAT > 1) ? $clog2(HD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       bloco_q, bloco_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] hd_addr_q, hd_addr_d;
    logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LAT_W-1:0]  wait_q, wait_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] tbl_q [NUM_BLOCKS];

    logic              in_range;
    logic [ADDR_W-1:0] len_rd;
    logic [ADDR_W-1:0] base_calc;

    always_comb begin
        in_range  = bloco_q < 32'(NUM_BLOCKS);
        len_rd    = in_range ? tbl_q[bloco_q[IDX_W-1:0]] : '0;
        base_calc = ADDR_W'(bloco_q) * ADDR_W'(BLOCK_SIZE);
    end

    always_comb begin
        state_d     = state_q;
        bloco_d     = bloco_q;
        len_d       = len_q;
        k_d         = k_q;
        hd_addr_d   = hd_addr_q;
        inst_addr_d = inst_addr_q;
        data_d      = data_q;
        wait_d      = wait_q;
        err_d       = err_q;
        // Abort freezes every datapath register so the address outputs keep their values.
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bloco_d = bus.bloco;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    len_d = len_rd;
                    k_d   = '0;
                    if (!in_range || len_rd == '0 || len_rd > ADDR_W'(BLOCK_SIZE)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d     = 1'b0;
                        hd_addr_d = base_calc;
                        state_d   = ISSUE;
                    end
                end
                ISSUE: begin
                    wait_d  = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (wait_q == LAT_W'(HD_LAT - 1)) begin
                        data_d      = bus.hd_data;
                        inst_addr_d = k_q;
                        state_d     = WRITE;
                    end else begin
                        wait_d = wait_q + LAT_W'(1);
                    end
                end
                WRITE: begin
                    k_d = k_q + ADDR_W'(1);
                    if (k_d == len_q) begin
                        state_d = DONE;
                    end else begin
                        hd_addr_d = hd_addr_q + ADDR_W'(1);
                        state_d   = ISSUE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bloco_q     <= '0;
            len_q       <= '0;
            k_q         <= '0;
            hd_addr_q   <= '0;
            inst_addr_q <= '0;
            data_q      <= '0;
            wait_q      <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_BLOCKS; i++) tbl_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            bloco_q     <= bloco_d;
            len_q       <= len_d;
            k_q         <= k_d;
            hd_addr_q   <= hd_addr_d;
            inst_addr_q <= inst_addr_d;
            data_q      <= data_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            // Same-edge start still sees the new length: CHECK reads the table one cycle later.
            if (state_q == IDLE && bus.tbl_we && int'(bus.tbl_idx) < NUM_BLOCKS)
                tbl_q[bus.tbl_idx] <= bus.tbl_len;
        end
    end

    assign bus.hd_rd     = (state_q == ISSUE);
    assign bus.inst_we   = (state_q == WRITE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = (state_q == DONE) && err_q;
    assign bus.hd_addr   = hd_addr_q;
    assign bus.inst_addr = inst_addr_q;
    assign bus.inst_data = data_q;
endmodule

// File: tb/tb_carregador_hd.sv
// Scoreboard bench for carregador_hd: two instances (HD latency 1 and 3) share
// one stimulus bus gated by sel; a monitor checks every output event against queues.
module tb_carregador_hd;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BS = 200;
    localparam int NB = 8;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    carregador_hd_if #(.DATA_W(DW), .ADDR_W(AW), .IDX_W(IW)) if1 ();
    carregador_hd_if #(.DATA_W(DW), .ADDR_W(AW), .IDX_W(IW)) if3 ();

    carregador_hd #(.DATA_W(DW), .ADDR_W(AW), .BLOCK_SIZE(BS), .NUM_BLOCKS(NB), .HD_LAT(1))
        u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    carregador_hd #(.DATA_W(DW), .ADDR_W(AW), .BLOCK_SIZE(BS), .NUM_BLOCKS(NB), .HD_LAT(3))
        u_dut3 (.clk(clk), .reset(reset), .bus(if3));

    int          sel;
    logic        start, abort, tbl_we;
    logic [31:0] bloco;
    logic [IW-1:0] tbl_idx;
    logic [AW-1:0] tbl_len;

    always_comb begin
        if1.start   = start  && (sel == 0);
        if3.start   = start  && (sel == 1);
        if1.abort   = abort  && (sel == 0);
        if3.abort   = abort  && (sel == 1);
        if1.tbl_we  = tbl_we && (sel == 0);
        if3.tbl_we  = tbl_we && (sel == 1);
        if1.bloco   = bloco;
        if3.bloco   = bloco;
        if1.tbl_idx = tbl_idx;
        if3.tbl_idx = tbl_idx;
        if1.tbl_len = tbl_len;
        if3.tbl_len = tbl_len;
    end

    // HD model: the word for an address appears exactly HD_LAT cycles after hd_rd, noise otherwise.
    logic [31:0] salt;
    logic        v_sh [2][4];
    logic [31:0] a_sh [2][4];
    logic [31:0] junk [2];

    function automatic logic [31:0] hdw(input logic [31:0] a, input logic [31:0] sl);
        return (a * 32'h9E3779B1) ^ sl;
    endfunction

    always @(posedge clk) begin
        v_sh[0][1] <= if1.hd_rd;
        a_sh[0][1] <= if1.hd_addr;
        v_sh[1][1] <= if3.hd_rd;
        a_sh[1][1] <= if3.hd_addr;
        for (int s = 0; s < 2; s++) begin
            for (int i = 2; i < 4; i++) begin
                v_sh[s][i] <= v_sh[s][i-1];
                a_sh[s][i] <= a_sh[s][i-1];
            end
            junk[s] <= $urandom;
        end
    end

    assign if1.hd_data = (v_sh[0][1] === 1'b1) ? hdw(a_sh[0][1], salt) : junk[0];
    assign if3.hd_data = (v_sh[1][3] === 1'b1) ? hdw(a_sh[1][3], salt) : junk[1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rdq [2][$];
    logic [63:0] wrq [2][$];
    logic        dq  [2][$];
    logic [31:0] mtab [2][NB];
    bit          rd_seen [2];
    int          last_rd [2];
    int          rd_cnt  [2];
    int          wr_cnt  [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input int s, input string what);
        n_vec++;
        n_err++;
        $display("FAIL dut%0d unexpected %s: got an event, expected none (cycle %0d)", s, what, cyc);
    endtask

    task automatic observe(input int s, input logic rd, input logic [31:0] ha,
                           input logic we, input logic [31:0] ia, input logic [31:0] id,
                           input logic dn, input logic er);
        int          lat;
        logic [63:0] w;
        lat = (s == 0) ? 1 : 3;
        if (rd === 1'b1) begin
            if (rdq[s].size() == 0) unexpected(s, "hd_rd");
            else check($sformatf("dut%0d hd_addr", s), ha, rdq[s].pop_front());
            if (rd_seen[s]) check($sformatf("dut%0d rd_gap", s), 32'(cyc - last_rd[s]), 32'(lat + 2));
            rd_seen[s] = 1'b1;
            last_rd[s] = cyc;
            rd_cnt[s]++;
        end
        if (we === 1'b1) begin
            if (wrq[s].size() == 0) unexpected(s, "inst_we");
            else begin
                w = wrq[s].pop_front();
                check($sformatf("dut%0d inst_addr", s), ia, w[63:32]);
                check($sformatf("dut%0d inst_data", s), id, w[31:0]);
                check($sformatf("dut%0d rd_to_we", s), 32'(cyc - last_rd[s]), 32'(lat + 1));
            end
            wr_cnt[s]++;
        end
        if (dn === 1'b1) begin
            if (dq[s].size() == 0) unexpected(s, "done");
            else check($sformatf("dut%0d err", s), {31'd0, er}, {31'd0, dq[s].pop_front()});
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            observe(0, if1.hd_rd, if1.hd_addr, if1.inst_we, if1.inst_addr, if1.inst_data, if1.done, if1.err);
            observe(1, if3.hd_rd, if3.hd_addr, if3.inst_we, if3.inst_addr, if3.inst_data, if3.done, if3.err);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic flush(input int s);
        rdq[s].delete();
        wrq[s].delete();
        dq[s].delete();
    endtask

    function automatic logic busy_of(input int s);
        return (s == 0) ? if1.busy : if3.busy;
    endfunction

    task automatic zero_check(input int s);
        logic [4:0]  ctl;
        logic [31:0] ha, ia, id;
        if (s == 0) begin
            ctl = {if1.busy, if1.done, if1.err, if1.hd_rd, if1.inst_we};
            ha = if1.hd_addr; ia = if1.inst_addr; id = if1.inst_data;
        end else begin
            ctl = {if3.busy, if3.done, if3.err, if3.hd_rd, if3.inst_we};
            ha = if3.hd_addr; ia = if3.inst_addr; id = if3.inst_data;
        end
        check($sformatf("dut%0d reset ctl", s), {27'd0, ctl}, 32'd0);
        check($sformatf("dut%0d reset hd_addr", s), ha, 32'd0);
        check($sformatf("dut%0d reset inst_addr", s), ia, 32'd0);
        check($sformatf("dut%0d reset inst_data", s), id, 32'd0);
    endtask

    task automatic tbl_write(input int s, input int idx, input int len, input bit applied);
        sel = s; tbl_we = 1'b1; tbl_idx = IW'(idx); tbl_len = len;
        tick();
        tbl_we = 1'b0;
        if (applied) mtab[s][idx] = len;
    endtask

    // Reference: a valid block copies len words from base=bloco*BS into 0..len-1.
    task automatic start_load(input int s, input logic [31:0] b, input bit wr, input int idx, input int len);
        logic [31:0] l, base;
        sel = s; bloco = b; start = 1'b1;
        if (wr) begin
            tbl_we = 1'b1; tbl_idx = IW'(idx); tbl_len = len;
            mtab[s][idx] = len;
        end
        rd_seen[s] = 1'b0;
        l = (b < NB) ? mtab[s][b[IW-1:0]] : 32'd0;
        if (b >= NB || l == 0 || l > BS) dq[s].push_back(1'b1);
        else begin
            base = b * BS;
            for (int k = 0; k < int'(l); k++) begin
                rdq[s].push_back(base + k);
                wrq[s].push_back({32'(k), hdw(base + k, salt)});
            end
            dq[s].push_back(1'b0);
        end
        tick();
        start = 1'b0; tbl_we = 1'b0;
    endtask

    task automatic wait_idle(input int s, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rdq[s].size() == 0 && wrq[s].size() == 0 && dq[s].size() == 0 && busy_of(s) == 1'b0)
                return;
        end
        n_vec++;
        n_err++;
        $display("FAIL dut%0d timeout: got %0d reads/%0d writes/%0d done pending, expected none",
                 s, rdq[s].size(), wrq[s].size(), dq[s].size());
        flush(s);
    endtask

    function automatic int pick_len();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return BS + 1 + $urandom_range(0, 20);
        if (r == 2) return BS;
        return $urandom_range(1, 8);
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        salt = $urandom;
        sel = 0; start = 1'b0; abort = 1'b0; tbl_we = 1'b0;
        bloco = '0; tbl_idx = '0; tbl_len = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NB; i++) mtab[s][i] = 32'd0;
            rd_seen[s] = 1'b0; last_rd[s] = 0; rd_cnt[s] = 0; wr_cnt[s] = 0;
        end
        reset = 1'b0;
        repeat (3) tick();
        zero_check(0);
        zero_check(1);
        reset = 1'b1;
        tick();

        // Basic 3-word load and same-edge table write + start
        tbl_write(0, 2, 3, 1'b1);
        start_load(0, 32'd2, 1'b0, 0, 0);
        wait_idle(0, 100);
        start_load(0, 32'd6, 1'b1, 6, 2);
        wait_idle(0, 100);

        // Rejects, then the largest legal length
        start_load(0, 32'd9, 1'b0, 0, 0);
        wait_idle(0, 20);
        tbl_write(0, 1, 0, 1'b1);
        start_load(0, 32'd1, 1'b0, 0, 0);
        wait_idle(0, 20);
        tbl_write(0, 0, 201, 1'b1);
        start_load(0, 32'd0, 1'b0, 0, 0);
        wait_idle(0, 20);
        tbl_write(0, 7, 200, 1'b1);
        start_load(0, 32'd7, 1'b0, 0, 0);
        wait_idle(0, 700);

        // Latency-3 instance timing
        tbl_write(1, 2, 4, 1'b1);
        start_load(1, 32'd2, 1'b0, 0, 0);
        wait_idle(1, 100);

        // Abort after the second write of a 5-word load
        tbl_write(0, 3, 5, 1'b1);
        wr_cnt[0] = 0;
        start_load(0, 32'd3, 1'b0, 0, 0);
        for (int i = 0; i < 60 && wr_cnt[0] < 2; i++) tick();
        check("dut0 writes before abort", 32'(wr_cnt[0]), 32'd2);
        sel = 0; abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("dut0 busy after abort", {31'd0, if1.busy}, 32'd0);
        flush(0);
        repeat (10) tick();
        start_load(0, 32'd3, 1'b0, 0, 0);
        wait_idle(0, 100);

        // Start and table write while busy are both ignored
        tbl_write(0, 4, 6, 1'b1);
        start_load(0, 32'd4, 1'b0, 0, 0);
        repeat (3) tick();
        sel = 0; bloco = 32'd1; start = 1'b1; tbl_we = 1'b1; tbl_idx = IW'(4); tbl_len = 32'd2;
        tick();
        start = 1'b0; tbl_we = 1'b0;
        wait_idle(0, 200);
        start_load(0, 32'd4, 1'b0, 0, 0);
        wait_idle(0, 200);

        // Reset during WAIT on the latency-3 instance
        tbl_write(1, 5, 4, 1'b1);
        rd_cnt[1] = 0;
        start_load(1, 32'd5, 1'b0, 0, 0);
        for (int i = 0; i < 20 && rd_cnt[1] == 0; i++) tick();
        tick();
        reset = 1'b0;
        #1;
        zero_check(1);
        zero_check(0);
        for (int s = 0; s < 2; s++) begin
            flush(s);
            for (int i = 0; i < NB; i++) mtab[s][i] = 32'd0;
        end
        tick();
        reset = 1'b1;
        tick();
        start_load(1, 32'd5, 1'b0, 0, 0);
        wait_idle(1, 20);
        start_load(0, 32'd4, 1'b0, 0, 0);
        wait_idle(0, 20);

        // Randomized traffic on both instances
        for (int it = 0; it < 40; it++) begin
            int          s, r;
            logic [31:0] b;
            s = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r < 4) begin
                tbl_write(s, $urandom_range(0, NB - 1), pick_len(), 1'b1);
            end else begin
                b = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, NB + 1));
                start_load(s, b, $urandom_range(0, 3) == 0, $urandom_range(0, NB - 1), pick_len());
                wait_idle(s, 1200);
            end
        end

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
